text_char_buffer: RTL and testbench
===================================

Name: text_char_buffer

Overview:
- Responder side of the character-text overlay interface.
- Holds a 16x16 text page in internal RAM (256 entries x 7-bit char codes).
- Answers each char_xy/char_line lookup from the overlay renderer with the matching 8-pixel font row, fetched through an external synchronous font ROM.
- Host-side write port with an auto-incrementing cursor; clear-screen state machine fills the page with a blank character.

Parameters:
CLEAR_CHAR, 7'h20, char code written to every cell during a clear
CLEAR_ON_RESET, 1, 1: enter CLEAR after reset; 0: enter IDLE, RAM contents undefined

Ports:
pclk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
char_xy  in  8  {row[3:0], col[3:0]} of requested cell
char_line  in  4  font row within the cell (0..15)
char_pixels  out  8  font row bits; bit7 = leftmost pixel
font_addr  out  11  {char_code[6:0], line[3:0]} to font ROM
font_data  in  8  font ROM output; valid 1 pclk after font_addr
wr_valid  in  1  host write request
wr_char  in  7  char code to write at cursor
wr_ready  out  1  write accepted when wr_valid && wr_ready
cur_load  in  1  load cursor from cur_xy
cur_xy  in  8  new cursor position
clr_req  in  1  start clear (level or pulse; sampled in IDLE)
busy  out  1  high while clearing
cursor  out  8  current cursor position

Behaviour:
- Reset values: char_pixels 0, font_addr 0, cursor 0. With CLEAR_ON_RESET=1: busy 1, wr_ready 0. With CLEAR_ON_RESET=0: busy 0, wr_ready 1. RAM contents are not reset.
- Read pipeline, fixed latency 3 pclk:
  - Edge N: RAM read of char_xy registered into code_q; char_line delayed into line_q.
  - font_addr = {code_q, line_q}, registered, valid after edge N+1.
  - ROM returns font_data at edge N+2.
  - char_pixels registered from font_data at edge N+3.
- The read path runs continuously, independent of FSM state, including during CLEAR.
- RAM collision: a read and a write to the same address in the same edge return the old data (read-first).
- FSM states:
  - IDLE: wr_ready=1, busy=0. clr_req=1 -> CLEAR with clr_cnt=0. clr_req has priority over wr_valid and cur_load in the same cycle; neither is performed.
  - CLEAR: wr_ready=0, busy=1. Each cycle writes CLEAR_CHAR at clr_cnt, then clr_cnt++. Exactly 256 cycles. After writing clr_cnt=255: cursor<=0, go to IDLE.
  - wr_valid, cur_load and clr_req are ignored in CLEAR.
- Cursor (IDLE only):
  - Accepted write stores wr_char at the write address, then cursor <= write address + 1.
  - Write address = cur_xy if cur_load is high the same cycle, else cursor.
  - cur_load without a write: cursor <= cur_xy.
  - Arithmetic is 8-bit modulo: 0xFF+1 wraps to 0x00, i.e. row 15 col 15 wraps to row 0 col 0.
- rst high at any time, including mid-CLEAR: immediate return to reset values. With CLEAR_ON_RESET=1 the clear restarts from clr_cnt 0 after rst deasserts.
- wr_ready is a registered state decode; it does not depend combinationally on wr_valid.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, hold rst 2 cycles -> busy=1 for exactly 256 cycles after rst deasserts, then busy=0, wr_ready=1, cursor=0. Read any xy -> font_addr[10:4]=7'h20.
2. Read latency: model ROM returning {code[0],line,3'b0}. Write 'A' (7'h41) at xy 0x12, then drive char_xy=0x12, char_line=5 at edge N -> font_addr=11'h415 after N+1; char_pixels=ROM(0x415) after N+3.
3. Streaming writes: cur_load cur_xy=0xFE, then wr_char 0x31,0x32,0x33 back-to-back -> cells 0xFE,0xFF,0x00 hold 0x31,0x32,0x33; cursor=0x01 (wrap).
4. Simultaneous events in IDLE: cur_load=1 cur_xy=0x40 with wr_valid=1 wr_char=0x5A -> cell 0x40=0x5A, cursor=0x41. Same cycle with clr_req=1 -> no write, CLEAR entered, cursor=0 at end.
5. Writes during CLEAR: assert wr_valid for 10 cycles mid-clear -> wr_ready=0, no write lands, all 256 cells read 7'h20 afterwards.
6. Reset mid-clear at clr_cnt=100 -> outputs return to reset values; full 256-cycle clear repeats; read-first collision check: write 0x41 at 0x10 while reading 0x10 -> old code appears on font_addr.

Source files
------------

// File: rtl/text_char_if.sv
// Overlay-renderer, font-ROM and host-write signals of the character text buffer.
// The master side drives lookups and writes and returns ROM data; the slave side is the buffer.
interface text_char_if;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [7:0]  char_pixels;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        wr_valid;
    logic [6:0]  wr_char;
    logic        wr_ready;
    logic        cur_load;
    logic [7:0]  cur_xy;
    logic        clr_req;
    logic        busy;
    logic [7:0]  cursor;

    modport master (
        output char_xy, char_line, font_data, wr_valid, wr_char, cur_load, cur_xy, clr_req,
        input  char_pixels, font_addr, wr_ready, busy, cursor
    );

    modport slave (
        input  char_xy, char_line, font_data, wr_valid, wr_char, cur_load, cur_xy, clr_req,
        output char_pixels, font_addr, wr_ready, busy, cursor
    );
endinterface

// File: rtl/text_char_buffer.sv
// 16x16 character page with a fixed 3-cycle font lookup pipeline, a host write port
// with auto-incrementing cursor, and a clear-screen sequencer.
module text_char_buffer #(
    parameter logic [6:0] CLEAR_CHAR     = 7'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic         pclk,
    input  logic         rst,
    text_char_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic [10:0] pack_font_addr(input logic [6:0] code, input logic [3:0] line);
        return {code, line};
    endfunction

    logic [6:0]  ram_r [0:255];
    logic [6:0]  code_r;
    logic [3:0]  line_r;
    logic [10:0] font_addr_r;
    logic [7:0]  char_pixels_r;

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  clr_cnt_r;
    logic [7:0]  clr_cnt_nxt_s;
    logic [7:0]  cursor_r;
    logic [7:0]  cursor_nxt_s;
    logic        wr_ready_r;
    logic        busy_r;

    logic        ram_we_s;
    logic [7:0]  ram_waddr_s;
    logic [6:0]  ram_wdata_s;
    logic [7:0]  wr_addr_s;

    // Page RAM: single write port, read-first so a same-edge write returns the old code
    always_ff @(posedge pclk) begin
        code_r <= ram_r[bus.char_xy];
        if (ram_we_s && !rst) begin
            ram_r[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // Font lookup pipeline, free-running regardless of FSM state
    always_ff @(posedge pclk) begin
        if (rst) begin
            line_r        <= 4'h0;
            font_addr_r   <= 11'h000;
            char_pixels_r <= 8'h00;
        end else begin
            line_r        <= bus.char_line;
            font_addr_r   <= pack_font_addr(code_r, line_r);
            char_pixels_r <= bus.font_data;
        end
    end

    // FSM state, counters and registered status decodes
    always_ff @(posedge pclk) begin
        if (rst) begin
            if (CLEAR_ON_RESET) begin
                state_r <= ST_CLEAR;
            end else begin
                state_r <= ST_IDLE;
            end
            clr_cnt_r  <= 8'h00;
            cursor_r   <= 8'h00;
            busy_r     <= CLEAR_ON_RESET;
            wr_ready_r <= !CLEAR_ON_RESET;
        end else begin
            state_r    <= next_state_s;
            clr_cnt_r  <= clr_cnt_nxt_s;
            cursor_r   <= cursor_nxt_s;
            busy_r     <= (next_state_s == ST_CLEAR);
            wr_ready_r <= (next_state_s == ST_IDLE);
        end
    end

    // Next-state, cursor update and RAM write-port selection
    always_comb begin
        next_state_s  = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        cursor_nxt_s  = cursor_r;
        ram_we_s      = 1'b0;
        ram_waddr_s   = 8'h00;
        ram_wdata_s   = 7'h00;
        // A cursor load in the same cycle as a write redirects that write
        wr_addr_s     = bus.cur_load ? bus.cur_xy : cursor_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    next_state_s  = ST_CLEAR;
                    clr_cnt_nxt_s = 8'h00;
                end else if (bus.wr_valid && wr_ready_r) begin
                    ram_we_s     = 1'b1;
                    ram_waddr_s  = wr_addr_s;
                    ram_wdata_s  = bus.wr_char;
                    cursor_nxt_s = wr_addr_s + 8'd1;
                end else if (bus.cur_load) begin
                    cursor_nxt_s = bus.cur_xy;
                end else begin
                    cursor_nxt_s = cursor_r;
                end
            end
            ST_CLEAR: begin
                ram_we_s      = 1'b1;
                ram_waddr_s   = clr_cnt_r;
                ram_wdata_s   = CLEAR_CHAR;
                clr_cnt_nxt_s = clr_cnt_r + 8'd1;
                if (clr_cnt_r == 8'hFF) begin
                    next_state_s = ST_IDLE;
                    cursor_nxt_s = 8'h00;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.char_pixels = char_pixels_r;
    assign bus.font_addr   = font_addr_r;
    assign bus.wr_ready    = wr_ready_r;
    assign bus.busy        = busy_r;
    assign bus.cursor      = cursor_r;

endmodule

// File: tb/tb_text_char_buffer.sv
// Self-checking bench for text_char_buffer: vector table, directed corner sequences and
// randomized host/renderer traffic against a cell-array reference model.
module tb_text_char_buffer;

    logic pclk = 1'b0;
    logic rst;

    text_char_if bus();

    text_char_buffer #(
        .CLEAR_CHAR     (7'h20),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    function automatic logic [7:0] rom_f(input logic [10:0] a);
        return {a[4], a[3:0], 3'b000};
    endfunction

    // Synchronous font ROM: data one clock after address
    always @(posedge pclk) bus.font_data <= rom_f(bus.font_addr);

    int checks = 0;
    int errors = 0;
    logic [6:0] m_ram [0:255];
    logic [7:0] m_cursor;

    typedef struct {
        logic       cl;
        logic [7:0] cxy;
        logic       wv;
        logic [6:0] wc;
        logic [7:0] exp_cursor;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.wr_char  = 7'h00;
        bus.cur_load = 1'b0;
        bus.cur_xy   = 8'h00;
        bus.clr_req  = 1'b0;
    endtask

    task automatic drive_op(input logic cl, input logic [7:0] cxy, input logic wv,
                            input logic [6:0] wc, input logic clr);
        bus.cur_load = cl;
        bus.cur_xy   = cxy;
        bus.wr_valid = wv;
        bus.wr_char  = wc;
        bus.clr_req  = clr;
    endtask

    // Reference behaviour of one IDLE-state host cycle
    task automatic model_op(input logic cl, input logic [7:0] cxy, input logic wv, input logic [6:0] wc);
        logic [7:0] a;
        a = cl ? cxy : m_cursor;
        if (wv) begin
            m_ram[a] = wc;
            m_cursor = a + 8'd1;
        end else if (cl) begin
            m_cursor = cxy;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_ram[i] = 7'h20;
        m_cursor = 8'h00;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (n < 400) begin
            @(negedge pclk);
            n++;
            if (!bus.busy) break;
        end
    endtask

    task automatic read_cell(input logic [7:0] xy, input logic [3:0] line);
        logic [10:0] fa;
        fa = {m_ram[xy], line};
        @(negedge pclk);
        bus.char_xy   = xy;
        bus.char_line = line;
        repeat (2) @(negedge pclk);
        chk("read_fa", bus.font_addr, fa);
        repeat (2) @(negedge pclk);
        chk("read_px", bus.char_pixels, rom_f(fa));
    endtask

    // Streams reads of every cell back-to-back
    task automatic scan_all();
        logic [10:0] efa [0:259];
        for (int i = 0; i < 260; i++) begin
            @(negedge pclk);
            if (i >= 2) chk("scan_fa", bus.font_addr, efa[i-2]);
            if (i >= 4) chk("scan_px", bus.char_pixels, rom_f(efa[i-4]));
            if (i < 256) begin
                bus.char_xy   = 8'(i);
                bus.char_line = 4'(i * 7);
                efa[i]        = {m_ram[8'(i)], 4'(i * 7)};
            end else begin
                efa[i] = efa[255];
            end
        end
    endtask

    initial begin
        vec_t vecs [0:7];
        int n;
        logic [10:0] rfa [0:299];
        logic cl, wv;
        logic [7:0] cxy;
        logic [6:0] wc;

        vecs[0] = '{1'b1, 8'hFE, 1'b0, 7'h00, 8'hFE};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 7'h31, 8'hFF};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 7'h32, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 7'h33, 8'h01};
        vecs[4] = '{1'b1, 8'h40, 1'b1, 7'h5A, 8'h41};
        vecs[5] = '{1'b1, 8'h80, 1'b0, 7'h00, 8'h80};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 7'h00, 8'h80};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 7'h7F, 8'h81};

        // Reset and power-up clear
        rst = 1'b1;
        idle_inputs();
        bus.char_xy   = 8'h00;
        bus.char_line = 4'h0;
        m_cursor      = 8'h00;
        repeat (2) @(negedge pclk);
        chk("rst_px", bus.char_pixels, 8'h00);
        chk("rst_fa", bus.font_addr, 11'h000);
        chk("rst_cursor", bus.cursor, 8'h00);
        chk("rst_busy", bus.busy, 1'b1);
        chk("rst_wr_ready", bus.wr_ready, 1'b0);
        rst = 1'b0;
        count_busy(n);
        chk("init_clear_len", n, 256);
        chk("init_wr_ready", bus.wr_ready, 1'b1);
        chk("init_cursor", bus.cursor, 8'h00);
        model_clear();
        scan_all();

        // Exact read latency
        @(negedge pclk);
        drive_op(1'b1, 8'h12, 1'b1, 7'h41, 1'b0);
        model_op(1'b1, 8'h12, 1'b1, 7'h41);
        @(negedge pclk);
        idle_inputs();
        chk("wr_cursor", bus.cursor, 8'h13);
        bus.char_xy   = 8'h00;
        bus.char_line = 4'h0;
        repeat (4) @(negedge pclk);
        bus.char_xy   = 8'h12;
        bus.char_line = 4'h5;
        @(negedge pclk);
        chk("lat_fa_early", bus.font_addr, 11'h200);
        @(negedge pclk);
        chk("lat_fa", bus.font_addr, 11'h415);
        @(negedge pclk);
        chk("lat_px_early", bus.char_pixels, 8'h00);
        @(negedge pclk);
        chk("lat_px", bus.char_pixels, 8'hA8);

        // Cursor/write vector table, back-to-back
        for (int v = 0; v <= 8; v++) begin
            @(negedge pclk);
            if (v > 0) chk("vec_cursor", bus.cursor, vecs[v-1].exp_cursor);
            if (v < 8) begin
                drive_op(vecs[v].cl, vecs[v].cxy, vecs[v].wv, vecs[v].wc, 1'b0);
                model_op(vecs[v].cl, vecs[v].cxy, vecs[v].wv, vecs[v].wc);
            end else begin
                idle_inputs();
            end
        end
        read_cell(8'hFE, 4'h1);
        read_cell(8'hFF, 4'h2);
        read_cell(8'h00, 4'h3);
        read_cell(8'h40, 4'h4);
        read_cell(8'h80, 4'h9);

        // Randomized host writes interleaved with renderer lookups
        for (int c = 0; c < 300; c++) begin
            @(negedge pclk);
            if (c >= 1) chk("rnd_cursor", bus.cursor, m_cursor);
            if (c >= 2) chk("rnd_fa", bus.font_addr, rfa[c-2]);
            if (c >= 4) chk("rnd_px", bus.char_pixels, rom_f(rfa[c-4]));
            cl  = ($urandom_range(3) == 0);
            wv  = ($urandom_range(1) == 1);
            cxy = 8'($urandom);
            wc  = 7'($urandom);
            bus.char_xy   = 8'($urandom);
            bus.char_line = 4'($urandom);
            rfa[c] = {m_ram[bus.char_xy], bus.char_line};
            drive_op(cl, cxy, wv, wc, 1'b0);
            model_op(cl, cxy, wv, wc);
        end
        @(negedge pclk);
        idle_inputs();
        chk("rnd_cursor_end", bus.cursor, m_cursor);

        // Clear request beats a simultaneous load+write
        drive_op(1'b1, 8'h40, 1'b1, 7'h5A, 1'b0);
        model_op(1'b1, 8'h40, 1'b1, 7'h5A);
        @(negedge pclk);
        chk("pre_clr_cursor", bus.cursor, 8'h41);
        drive_op(1'b1, 8'h40, 1'b1, 7'h11, 1'b1);
        bus.char_xy   = 8'h40;
        bus.char_line = 4'h0;
        @(negedge pclk);
        idle_inputs();
        chk("clr_busy", bus.busy, 1'b1);
        chk("clr_wr_ready", bus.wr_ready, 1'b0);
        chk("clr_cursor_kept", bus.cursor, 8'h41);
        repeat (2) @(negedge pclk);
        chk("clr_no_write", bus.font_addr, 11'h5A0);
        count_busy(n);
        chk("clr_len", n + 3, 257);
        chk("clr_end_cursor", bus.cursor, 8'h00);
        chk("clr_end_wr_ready", bus.wr_ready, 1'b1);
        model_clear();

        // Host traffic during clear is refused
        @(negedge pclk);
        drive_op(1'b0, 8'h00, 1'b0, 7'h00, 1'b1);
        @(negedge pclk);
        idle_inputs();
        repeat (99) @(negedge pclk);
        for (int j = 0; j < 10; j++) begin
            drive_op(1'b1, 8'(j), 1'b1, 7'h7F, 1'b1);
            @(negedge pclk);
            chk("blk_wr_ready", bus.wr_ready, 1'b0);
            chk("blk_busy", bus.busy, 1'b1);
        end
        idle_inputs();
        count_busy(n);
        chk("blk_clr_len", n + 110, 257);
        chk("blk_cursor", bus.cursor, 8'h00);
        scan_all();

        // Reset in the middle of a clear
        @(negedge pclk);
        drive_op(1'b1, 8'd200, 1'b1, 7'h55, 1'b0);
        model_op(1'b1, 8'd200, 1'b1, 7'h55);
        for (int j = 0; j < 5; j++) begin
            @(negedge pclk);
            drive_op(1'b0, 8'h00, 1'b1, 7'(7'h56 + j), 1'b0);
            model_op(1'b0, 8'h00, 1'b1, 7'(7'h56 + j));
        end
        @(negedge pclk);
        drive_op(1'b1, 8'h77, 1'b0, 7'h00, 1'b0);
        model_op(1'b1, 8'h77, 1'b0, 7'h00);
        @(negedge pclk);
        idle_inputs();
        chk("mid_pre_cursor", bus.cursor, 8'h77);
        read_cell(8'd203, 4'h2);
        @(negedge pclk);
        drive_op(1'b0, 8'h00, 1'b0, 7'h00, 1'b1);
        bus.char_xy   = 8'h00;
        bus.char_line = 4'h7;
        @(negedge pclk);
        idle_inputs();
        repeat (100) @(negedge pclk);
        chk("mid_fa_before_rst", bus.font_addr, 11'h207);
        chk("mid_cursor_before_rst", bus.cursor, 8'h77);
        rst = 1'b1;
        @(negedge pclk);
        chk("mid_rst_px", bus.char_pixels, 8'h00);
        chk("mid_rst_fa", bus.font_addr, 11'h000);
        chk("mid_rst_cursor", bus.cursor, 8'h00);
        chk("mid_rst_busy", bus.busy, 1'b1);
        chk("mid_rst_wr_ready", bus.wr_ready, 1'b0);
        @(negedge pclk);
        rst = 1'b0;
        count_busy(n);
        chk("mid_restart_len", n, 256);
        model_clear();
        scan_all();

        // Read-first collision
        @(negedge pclk);
        drive_op(1'b1, 8'h10, 1'b1, 7'h41, 1'b0);
        model_op(1'b1, 8'h10, 1'b1, 7'h41);
        bus.char_xy   = 8'h10;
        bus.char_line = 4'h3;
        @(negedge pclk);
        idle_inputs();
        @(negedge pclk);
        chk("coll_old", bus.font_addr, 11'h203);
        @(negedge pclk);
        chk("coll_new", bus.font_addr, 11'h413);
        chk("coll_cursor", bus.cursor, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
